btb_hit_qualifier: RTL and testbench
====================================

# btb_hit_qualifier

Registered, parametrised hit qualifier for the set-associative branch target buffer. It takes raw per-way tag-match lines plus per-way kill lines and a pipeline flush. It produces one clean hit, the winning way index, and a multi-hit error indication one cycle after lookup. It sits between the BTB tag-compare array and the fetch-stage next-PC mux, and adds a post-flush blanking window and a saturating hit counter for performance monitoring.

## Interface
- WAYS, 4: number of BTB ways; legal range 1..16.
- WAYW, $clog2(WAYS) (minimum 1): width of the way index.
- HOLD_CYCLES, 2: number of cycles lookups are suppressed after a flush; legal range 1..15.
- CNTW, 16: width of the hit counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  a lookup is presented this cycle.
- way_hit  in  WAYS  raw tag match per way.
- way_kill  in  WAYS  per-way invalidate; a killed way never hits.
- flush  in  1  pipeline redirect; starts blanking.
- cnt_clr  in  1  synchronous clear of hit_cnt.
- err_clr  in  1  synchronous clear of multi_err.
- hit  out  1  qualified hit (registered).
- hit_way  out  WAYW  lowest-index qualified way; 0 when hit=0.
- multi_hit  out  1  more than one qualified way this lookup (one-cycle pulse).
- multi_err  out  1  sticky multi-hit flag.
- suppressed  out  1  a lookup was dropped by blanking or flush.
- hit_cnt  out  CNTW  saturating count of qualified hits.

## Operation
- qual[i] = way_hit[i] & ~way_kill[i].
- States:
  - RUN: normal operation.
  - BLANK: blanking window, with a down-counter blank_cnt of width 4.
- Reset values: state RUN, blank_cnt 0, all outputs 0.
- RUN, lookup_valid=1, flush=0:
  - hit <= |qual.
  - hit_way <= lowest set index of qual, or 0 if none.
  - multi_hit <= (popcount(qual) > 1).
  - suppressed <= 0.
- RUN, lookup_valid=0: hit, multi_hit and suppressed <= 0; hit_way <= 0.
- flush=1 in any state:
  - Next state BLANK, blank_cnt <= HOLD_CYCLES.
  - hit, multi_hit <= 0; suppressed <= lookup_valid.
  - Flush has priority over a same-cycle lookup.
- BLANK, flush=0:
  - hit, multi_hit <= 0; suppressed <= lookup_valid.
  - blank_cnt decrements each cycle.
  - When blank_cnt==1, the next state is RUN.
  - A flush during BLANK reloads blank_cnt to HOLD_CYCLES.
- multi_err: set on any cycle that drives multi_hit to 1; cleared by err_clr. If set and clear occur together, set wins.
- hit_cnt: increments when hit is registered 1, and saturates at all-ones. cnt_clr forces 0 and wins over a simultaneous increment.
- Inputs are don't-care when lookup_valid=0. X on way_hit must not propagate into hit while lookup_valid=0.

## Timing
- Latency: lookup sampled at edge N produces hit, hit_way, multi_hit and suppressed valid after edge N, i.e. in cycle N+1. hit_cnt and multi_err reflect that lookup one edge later (N+2).
- Blanking: flush sampled at edge N makes lookups sampled at edges N through N+HOLD_CYCLES suppressed. The first honoured lookup is sampled at edge N+HOLD_CYCLES+1.
- Back-to-back lookups are supported every cycle; no backpressure.
- rst_n low at any time: all state and outputs clear immediately and asynchronously. Release is synchronous to clk; the first lookup is honoured at the first edge with rst_n high.

## Structure
- A shared package btb_pkg holds the state enum (ST_RUN, ST_BLANK) and a constant for the blank_cnt width.
- One sub-module: btb_way_prio_enc, parametrised by WAYS. Inputs: qual vector. Outputs: any, idx (lowest index), multi.
- The top level holds the FSM, registers and counters.

## Test plan
- WAYS=4, lookup_valid=1, way_hit=4'b0100, way_kill=0 -> next cycle hit=1, hit_way=2, multi_hit=0; hit_cnt=1 one cycle later.
- way_hit=4'b1010, way_kill=4'b0010 -> hit=1, hit_way=3, multi_hit=0. Then way_hit=4'b0110, way_kill=0 -> hit=1, hit_way=1, multi_hit=1, multi_err=1; err_clr then clears it.
- HOLD_CYCLES=2, flush at edge 10, lookups with way_hit=4'b0001 at edges 10–13 -> suppressed=1 and hit=0 for edges 10–12; hit=1 for the edge-13 lookup. A second flush at edge 11 extends suppression through edge 13.
- CNTW=4, 20 consecutive hits -> hit_cnt stays at 15. cnt_clr coinciding with a hit -> hit_cnt=0.
- way_hit=4'b1111 with way_kill=4'b1111 -> hit=0, hit_way=0, hit_cnt unchanged.
- rst_n pulsed low mid-BLANK with hit=1 registered -> all outputs 0 immediately. After release, state is RUN and the first lookup hits with no blanking.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB hit qualifier.
package btb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam int BLANK_CNT_W = 4;

endpackage

// File: rtl/btb_way_prio_enc.sv
// Lowest-index priority encoder over qualified BTB ways, with any/multi flags.
module btb_way_prio_enc #(
    parameter int WAYS = 4,
    parameter int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0] qual,
    output logic            any,
    output logic [WAYW-1:0] idx,
    output logic            multi
);

    always_comb begin
        idx = '0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (qual[i]) idx = WAYW'(i);
        end
    end

    assign any = |qual;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(qual & (qual - WAYS'(1)));

endmodule

// File: rtl/btb_hit_qualifier.sv
// Registered BTB hit qualifier: per-way kill, post-flush blanking, multi-hit
// detection and a saturating hit counter.
module btb_hit_qualifier
    import btb_pkg::*;
#(
    parameter int WAYS        = 4,
    parameter int WAYW        = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int HOLD_CYCLES = 2,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [WAYS-1:0] way_hit,
    input  logic [WAYS-1:0] way_kill,
    input  logic            flush,
    input  logic            cnt_clr,
    input  logic            err_clr,
    output logic            hit,
    output logic [WAYW-1:0] hit_way,
    output logic            multi_hit,
    output logic            multi_err,
    output logic            suppressed,
    output logic [CNTW-1:0] hit_cnt
);

    localparam logic [BLANK_CNT_W-1:0] HOLD_LD = BLANK_CNT_W'(HOLD_CYCLES);

    logic [WAYS-1:0]        qual;
    logic                   q_any;
    logic [WAYW-1:0]        q_idx;
    logic                   q_multi;
    state_t                 state;
    logic [BLANK_CNT_W-1:0] blank_cnt;

    // Gate on lookup_valid so garbage tag lines never reach the registers.
    assign qual = lookup_valid ? (way_hit & ~way_kill) : '0;

    btb_way_prio_enc #(
        .WAYS (WAYS),
        .WAYW (WAYW)
    ) u_prio_enc (
        .qual  (qual),
        .any   (q_any),
        .idx   (q_idx),
        .multi (q_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            blank_cnt  <= '0;
            hit        <= 1'b0;
            hit_way    <= '0;
            multi_hit  <= 1'b0;
            multi_err  <= 1'b0;
            suppressed <= 1'b0;
            hit_cnt    <= '0;
        end else begin
            if (flush) begin
                state      <= ST_BLANK;
                blank_cnt  <= HOLD_LD;
                hit        <= 1'b0;
                hit_way    <= '0;
                multi_hit  <= 1'b0;
                suppressed <= lookup_valid;
            end else if (state == ST_BLANK) begin
                hit        <= 1'b0;
                hit_way    <= '0;
                multi_hit  <= 1'b0;
                suppressed <= lookup_valid;
                if (blank_cnt <= BLANK_CNT_W'(1)) begin
                    state     <= ST_RUN;
                    blank_cnt <= '0;
                end else begin
                    blank_cnt <= blank_cnt - BLANK_CNT_W'(1);
                end
            end else begin
                hit        <= q_any;
                hit_way    <= q_idx;
                multi_hit  <= q_multi;
                suppressed <= 1'b0;
            end

            // Set wins over clear for the sticky error.
            multi_err <= multi_hit | (multi_err & ~err_clr);

            if (cnt_clr) hit_cnt <= '0;
            else if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_btb_hit_qualifier.sv
// Directed bench for btb_hit_qualifier with hand-computed expectations.
module tb_btb_hit_qualifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lookup_valid;
    logic [3:0] way_hit;
    logic [3:0] way_kill;
    logic       flush;
    logic       cnt_clr;
    logic       err_clr;
    logic       hit;
    logic [1:0] hit_way;
    logic       multi_hit;
    logic       multi_err;
    logic       suppressed;
    logic [3:0] hit_cnt;

    int errors = 0;
    int checks = 0;

    btb_hit_qualifier #(
        .WAYS        (4),
        .HOLD_CYCLES (2),
        .CNTW        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .way_hit      (way_hit),
        .way_kill     (way_kill),
        .flush        (flush),
        .cnt_clr      (cnt_clr),
        .err_clr      (err_clr),
        .hit          (hit),
        .hit_way      (hit_way),
        .multi_hit    (multi_hit),
        .multi_err    (multi_err),
        .suppressed   (suppressed),
        .hit_cnt      (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [3:0] h, input logic [3:0] k);
        lookup_valid = 1'b1;
        way_hit      = h;
        way_kill     = k;
    endtask

    task automatic idle();
        lookup_valid = 1'b0;
        way_hit      = 4'b0;
        way_kill     = 4'b0;
    endtask

    task automatic chk_out(input string tag, input logic h, input logic [1:0] w,
                           input logic m, input logic s);
        chk({tag, ".hit"}, 32'(hit), 32'(h));
        chk({tag, ".way"}, 32'(hit_way), 32'(w));
        chk({tag, ".multi"}, 32'(multi_hit), 32'(m));
        chk({tag, ".supp"}, 32'(suppressed), 32'(s));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; cnt_clr = 1'b0; err_clr = 1'b0;
        idle();
        tick(); tick();
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.cnt", 32'(hit_cnt), 32'd0);
        chk("reset.err", 32'(multi_err), 32'd0);
        rst_n = 1'b1;

        // Single-way hit, counter one edge later.
        look(4'b0100, 4'b0000); tick();
        chk_out("t1", 1'b1, 2'd2, 1'b0, 1'b0);
        chk("t1.cnt_lag", 32'(hit_cnt), 32'd0);
        idle(); tick();
        chk("t1.cnt", 32'(hit_cnt), 32'd1);
        chk("t1.idle_hit", 32'(hit), 32'd0);

        // Killed way falls through to way 3; then a true multi-hit.
        look(4'b1010, 4'b0010); tick();
        chk_out("t2a", 1'b1, 2'd3, 1'b0, 1'b0);
        look(4'b0110, 4'b0000); tick();
        chk_out("t2b", 1'b1, 2'd1, 1'b1, 1'b0);
        chk("t2b.err_lag", 32'(multi_err), 32'd0);
        idle(); tick();
        chk("t2.err", 32'(multi_err), 32'd1);
        chk("t2.cnt", 32'(hit_cnt), 32'd3);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t2.err_clr", 32'(multi_err), 32'd0);

        // Every way killed.
        look(4'b1111, 4'b1111); tick();
        chk_out("kill", 1'b0, 2'd0, 1'b0, 1'b0);
        idle(); tick();
        chk("kill.cnt", 32'(hit_cnt), 32'd3);

        // Invalid lookup with all tag lines high must not hit.
        lookup_valid = 1'b0; way_hit = 4'b1111; tick();
        chk("inv.hit", 32'(hit), 32'd0);
        idle();

        // Flush at edge N: lookups N..N+2 suppressed, N+3 honoured.
        look(4'b0001, 4'b0000); flush = 1'b1; tick(); flush = 1'b0;
        chk_out("bl0", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("bl1", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("bl2", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("bl3", 1'b1, 2'd0, 1'b0, 1'b0);

        // Second flush one edge later extends suppression by one.
        flush = 1'b1; tick();
        chk_out("rf0", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); flush = 1'b0;
        chk_out("rf1", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("rf2", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("rf3", 1'b0, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("rf4", 1'b1, 2'd0, 1'b0, 1'b0);

        // Blanking with no lookup reports nothing suppressed.
        idle(); flush = 1'b1; tick(); flush = 1'b0;
        chk("blidle.supp", 32'(suppressed), 32'd0);
        tick(); tick();

        // Saturation at 15.
        look(4'b0001, 4'b0000);
        for (int i = 0; i < 20; i++) tick();
        chk("sat.run", 32'(hit_cnt), 32'd15);
        idle(); tick(); tick();
        chk("sat.hold", 32'(hit_cnt), 32'd15);

        // Clear wins over a simultaneous increment.
        look(4'b1000, 4'b0000); tick();
        chk("clr.hit", 32'(hit), 32'd1);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr.cnt", 32'(hit_cnt), 32'd0);
        idle(); tick();
        chk("clr.resume", 32'(hit_cnt), 32'd1);

        // Set wins over a simultaneous err_clr.
        look(4'b0011, 4'b0000); tick();
        chk("sw.multi", 32'(multi_hit), 32'd1);
        idle(); err_clr = 1'b1; tick();
        chk("sw.set_wins", 32'(multi_err), 32'd1);
        tick(); err_clr = 1'b0;
        chk("sw.cleared", 32'(multi_err), 32'd0);

        // Async reset mid-blank with hit and counter non-zero.
        look(4'b0011, 4'b0000); tick();
        chk("ar.pre_hit", 32'(hit), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("ar", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("ar.cnt", 32'(hit_cnt), 32'd0);
        chk("ar.err", 32'(multi_err), 32'd0);
        #1 rst_n = 1'b1;
        look(4'b0100, 4'b0000); tick();
        chk_out("ar.first", 1'b1, 2'd2, 1'b0, 1'b0);
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
